// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron datapath blocks.
//   state_t   : controller state encoding for the LIF update engine
//   RST_*     : membrane reset-mode selector values
//   DEF_*     : default layer geometry and datapath widths
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULT  = 2'd1,
    ST_WRITE = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam logic RST_ZERO = 1'b0;
  localparam logic RST_SUB  = 1'b1;

  localparam int DEF_NEURONS = 16;
  localparam int DEF_LANES   = 4;
  localparam int DEF_POT_W   = 8;
  localparam int DEF_BETA_W  = 4;

endpackage

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, LSB first.
// Ports:
//   clk, reset    : clock, synchronous active-low reset (control state only)
//   start         : load a/b and clear the accumulator
//   a [A_W]       : multiplicand (unsigned)
//   b [B_W]       : multiplier (unsigned)
//   product       : A_W+B_W-bit result, valid while done is high
//   done          : set B_W cycles after start, cleared by the next start
module seq_shift_add_mult #(
  parameter int A_W = 8,
  parameter int B_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic [A_W+B_W-1:0] product,
  output logic               done
);

  localparam int P_W = A_W + B_W;
  localparam int C_W = (B_W > 1) ? $clog2(B_W) : 1;

  logic [P_W-1:0] a_sh;
  logic [B_W-1:0] b_sh;
  logic [P_W-1:0] acc;
  logic [C_W-1:0] cnt;
  logic           active;
  logic           last_step;

  assign last_step = active && (cnt == C_W'(B_W - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      active <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      done   <= 1'b0;
    end else if (active) begin
      cnt <= cnt + C_W'(1);
      if (last_step) begin
        active <= 1'b0;
        done   <= 1'b1;
      end
    end
  end

  // a_sh carries a << step, so each set multiplier bit adds its weighted copy.
  always_ff @(posedge clk) begin
    if (start) begin
      a_sh <= P_W'(a);
      b_sh <= b;
      acc  <= '0;
    end else if (active) begin
      if (b_sh[0]) acc <= acc + a_sh;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
    end
  end

  assign product = acc;

endmodule

// File: rtl/lif_update_engine.sv
// Time-multiplexed leaky integrate-and-fire membrane update engine.
// A whole layer vector is captured on accept, then processed LANES neurons
// per group: BETA_W cycles of shift-add decay multiply, one WRITE cycle that
// integrates, saturates, thresholds and resets, then the next group.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   in_valid / in_ready   : input vector handshake
//   pot_in, beta_in,
//   cur_in                : potentials, decay factors, currents (neuron i at i*W)
//   threshold, reset_mode : firing threshold, 0 = reset to zero, 1 = subtract
//   out_valid / out_ready : result handshake
//   pot_out, spk_out      : updated potentials and spike vector
//   busy                  : engine not idle
module lif_update_engine
  import snn_pkg::*;
#(
  parameter int NEURONS = DEF_NEURONS,
  parameter int LANES   = DEF_LANES,
  parameter int POT_W   = DEF_POT_W,
  parameter int BETA_W  = DEF_BETA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NEURONS*POT_W-1:0]  pot_in,
  input  logic [NEURONS*BETA_W-1:0] beta_in,
  input  logic [NEURONS*POT_W-1:0]  cur_in,
  input  logic [POT_W-1:0]          threshold,
  input  logic                      reset_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NEURONS*POT_W-1:0]  pot_out,
  output logic [NEURONS-1:0]        spk_out,
  output logic                      busy
);

  localparam int GROUPS = NEURONS / LANES;
  localparam int G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int C_W    = (BETA_W > 1) ? $clog2(BETA_W) : 1;
  localparam int P_W    = POT_W + BETA_W;

  state_t state, state_nxt;

  logic [G_W-1:0] grp, grp_nxt;
  logic [C_W-1:0] bit_cnt;
  logic           accept, last_bit, last_grp, all_done, mult_start, write_en;

  logic [NEURONS*POT_W-1:0]  pot_cap, cur_cap;
  logic [NEURONS*BETA_W-1:0] beta_cap;
  logic [POT_W-1:0]          thr_cap;
  logic                      mode_cap;

  logic [LANES*POT_W-1:0]  mul_a;
  logic [LANES*BETA_W-1:0] mul_b;
  logic [LANES*P_W-1:0]    mul_p;
  logic [LANES-1:0]        mul_done;

  logic [LANES-1:0][POT_W-1:0] lane_pot;
  logic [LANES-1:0]            lane_spk;

  logic [NEURONS*POT_W-1:0] pot_res;
  logic [NEURONS-1:0]       spk_res;

  // Floor of u*beta / 2^BETA_W.
  function automatic logic [POT_W-1:0] scale_floor(input logic [P_W-1:0] p);
    return POT_W'(p >> BETA_W);
  endfunction

  function automatic logic [POT_W-1:0] sat_add(input logic [POT_W-1:0] d,
                                               input logic [POT_W-1:0] c);
    logic [POT_W:0] s;
    s = {1'b0, d} + {1'b0, c};
    return s[POT_W] ? {POT_W{1'b1}} : s[POT_W-1:0];
  endfunction

  assign accept   = in_valid && in_ready;
  assign last_bit = (bit_cnt == C_W'(BETA_W - 1));
  assign last_grp = (grp == G_W'(GROUPS - 1));
  assign all_done = &mul_done;
  assign write_en = (state == ST_WRITE) && all_done;
  assign grp_nxt  = last_grp ? '0 : grp + G_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)    state_nxt = ST_MULT;
      ST_MULT:  if (last_bit)  state_nxt = ST_WRITE;
      ST_WRITE: if (all_done)  state_nxt = last_grp ? ST_OUT : ST_MULT;
      ST_OUT:   if (out_ready) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // in_ready is also gated by reset so it reads low while reset is held.
  always_comb begin
    in_ready   = (state == ST_IDLE) && reset;
    out_valid  = (state == ST_OUT);
    busy       = (state != ST_IDLE);
    mult_start = accept || (write_en && !last_grp);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      grp     <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      grp     <= '0;
      bit_cnt <= '0;
    end else if (state == ST_MULT) begin
      bit_cnt <= last_bit ? '0 : bit_cnt + C_W'(1);
    end else if (write_en && !last_grp) begin
      grp <= grp_nxt;
    end
  end

  // Vector capture: later input changes cannot disturb the vector in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      pot_cap  <= pot_in;
      beta_cap <= beta_in;
      cur_cap  <= cur_in;
      thr_cap  <= threshold;
      mode_cap <= reset_mode;
    end
  end

  // On accept the first group is loaded straight from the ports, since the
  // capture registers only fill on that same edge. From WRITE the next group
  // comes from the captured copy.
  always_comb begin
    int n;
    n     = 0;
    mul_a = '0;
    mul_b = '0;
    for (int l = 0; l < LANES; l++) begin
      if (state == ST_WRITE) n = int'(grp_nxt) * LANES + l;
      else                   n = l;
      if (accept) begin
        mul_a[l*POT_W +: POT_W]   = pot_in[n*POT_W +: POT_W];
        mul_b[l*BETA_W +: BETA_W] = beta_in[n*BETA_W +: BETA_W];
      end else begin
        mul_a[l*POT_W +: POT_W]   = pot_cap[n*POT_W +: POT_W];
        mul_b[l*BETA_W +: BETA_W] = beta_cap[n*BETA_W +: BETA_W];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    seq_shift_add_mult #(
      .A_W(POT_W),
      .B_W(BETA_W)
    ) u_mult (
      .clk    (clk),
      .reset  (reset),
      .start  (mult_start),
      .a      (mul_a[l*POT_W +: POT_W]),
      .b      (mul_b[l*BETA_W +: BETA_W]),
      .product(mul_p[l*P_W +: P_W]),
      .done   (mul_done[l])
    );
  end

  // WRITE datapath: integrate, saturate, threshold, spike reset.
  always_comb begin
    logic [POT_W-1:0] s;
    int n;
    s        = '0;
    n        = 0;
    lane_pot = '0;
    lane_spk = '0;
    for (int l = 0; l < LANES; l++) begin
      n = int'(grp) * LANES + l;
      s = sat_add(scale_floor(mul_p[l*P_W +: P_W]), cur_cap[n*POT_W +: POT_W]);
      lane_spk[l] = (s >= thr_cap);
      if (!lane_spk[l])             lane_pot[l] = s;
      else if (mode_cap == RST_SUB) lane_pot[l] = s - thr_cap;
      else                          lane_pot[l] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pot_res <= '0;
      spk_res <= '0;
    end else if (write_en) begin
      for (int l = 0; l < LANES; l++) begin
        pot_res[(int'(grp)*LANES + l)*POT_W +: POT_W] <= lane_pot[l];
        spk_res[int'(grp)*LANES + l]                  <= lane_spk[l];
      end
    end
  end

  assign pot_out = pot_res;
  assign spk_out = spk_res;

endmodule

// File: doc/lif_update_engine.md
# lif_update_engine

Parametrised, time-multiplexed membrane-potential update engine for a layer of leaky integrate-and-fire neurons. Accepts a full layer vector of potentials, per-neuron decay factors and input currents. Processes `LANES` neurons at a time through sequential shift-add multipliers, applying decay, integration, saturation, threshold and spike reset. Returns updated potentials and a spike vector over a valid/ready handshake. Sits between the potential memory and the spike memory controller, and succeeds the fixed 16-neuron combinational update processor.

## Interface
- `NEURONS`, 16: neurons per layer vector; must be a multiple of `LANES`.
- `LANES`, 4: neurons processed in parallel per group.
- `POT_W`, 8: potential, current and threshold width (unsigned).
- `BETA_W`, 4: decay-factor width; beta is a fraction, beta/2^BETA_W.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-low reset.
- `in_valid` in 1: input vector valid.
- `in_ready` out 1: engine can accept a vector.
- `pot_in` in NEURONS*POT_W: current potentials; neuron i is at [i*POT_W +: POT_W].
- `beta_in` in NEURONS*BETA_W: per-neuron decay factors.
- `cur_in` in NEURONS*POT_W: per-neuron input currents.
- `threshold` in POT_W: firing threshold; sampled at accept.
- `reset_mode` in 1: 0 = reset to zero on spike, 1 = subtract threshold; sampled at accept.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `pot_out` out NEURONS*POT_W: updated potentials.
- `spk_out` out NEURONS: spike vector; bit i belongs to neuron i.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - MULT: BETA_W cycles per group.
  - WRITE: 1 cycle per group.
  - OUT: hold result.
- Transitions:
  - IDLE→MULT on `in_valid`&`in_ready`. All inputs, `threshold` and `reset_mode` are captured into internal registers. Group index g=0.
  - MULT→WRITE after BETA_W cycles. Each lane's shift-add multiplier consumes one beta bit per cycle, LSB first.
  - WRITE→MULT with g+1 if g<NEURONS/LANES−1. Otherwise WRITE→OUT.
  - OUT→IDLE on `out_ready`.
- Per neuron, in WRITE:
  - d = (u*beta) >> BETA_W, floor; the product is POT_W+BETA_W bits.
  - s = d + cur, computed at POT_W+1 bits, then saturated to 2^POT_W−1.
  - spk = (s ≥ threshold).
  - u' = spk ? (mode ? s−threshold : 0) : s.
- Results are written into the `pot_out`/`spk_out` holding registers for lanes g*LANES..g*LANES+LANES−1.
- `pot_out`/`spk_out` are stable from OUT entry until the next WRITE of a new vector. They are not cleared on return to IDLE.
- Inputs changing after accept have no effect on the vector in flight.
- threshold=0: every neuron spikes. With mode 1, u'=s.

## Timing
- Reset values: `in_ready`=0 during reset and 1 the first cycle after; `out_valid`=0, `busy`=0, `pot_out`=0, `spk_out`=0; state IDLE; g=0.
- Latency: `out_valid` rises exactly (NEURONS/LANES)*(BETA_W+1) cycles after the accepting edge. With defaults this is 20 cycles.
- `out_valid` is held with data stable until `out_ready` is sampled high. The transfer occurs on the edge where both are high.
- No overlap: `in_ready`=0 from accept until the cycle after the output transfer. Throughput is one vector per latency+1 cycles when `out_ready` is tied high.
- Reset asserted mid-operation: at the next edge, abandon the vector, return to IDLE and apply all reset values. No partial result is presented.
- `in_valid` asserted during OUT is ignored. It is accepted only once the engine is back in IDLE.

## Structure
- Shared package `snn_pkg` holds:
  - state encoding (IDLE, MULT, WRITE, OUT);
  - reset-mode constants (RST_ZERO=0, RST_SUB=1);
  - default widths.
- Sub-module `seq_shift_add_mult` (params `A_W`, `B_W`) is instantiated `LANES` times.
  - Ports: `clk`, `reset`, `start`, `a`, `b`, `product`, `done`.
  - Produces an A_W+B_W-bit product B_W cycles after `start`.
- The controller (FSM, group counter, bit counter) and the WRITE datapath live in `lif_update_engine`.

## Test plan
All scenarios use the defaults: NEURONS=16, LANES=4, POT_W=8, BETA_W=4.
- Basic decay: u=100, beta=8, cur=10, threshold=64, mode 0 on all neurons → pot_out all 60, spk_out=0x0000, `out_valid` at cycle 20.
- Saturate and spike, zero reset: u=200, beta=15, cur=100, threshold=64, mode 0 → s=255 on all neurons, spk_out=0xFFFF, pot_out all 0.
- Subtract reset: same stimulus with mode 1 → pot_out all 191, spk_out=0xFFFF.
- Per-lane mapping: neuron i gets u=16*i, beta=15 (u=0 for i=0), cur=0, threshold=200. Expected values:
  - pot_out[i] = floor(240*i/16) = 15*i, with no spike, for i ≤ 13.
  - i=14: 210 ≥ 200, spikes; pot_out=0 under mode 0.
  - i=15: 225 ≥ 200, spikes; pot_out=0 under mode 0.
  - spk_out=0xC000.
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid` → data stable, `in_ready`=0, a concurrent `in_valid` is not accepted. Release `out_ready` → IDLE next cycle.
- Reset mid-operation: assert `reset`=0 at cycle 7 after accept → next cycle all outputs at their reset values. A new vector (beta=0, cur=5, threshold=64, mode 0) then gives pot_out all 5 and spk_out=0x0000.
